job_sched: RTL

// - Command scheduler in front of the matmul/PPU accelerator core (mm_ctrl + ppu).
// - Queues jobs {mode, relu_en, tag} from the host and launches them one at a time.
// - Each launch is a one-cycle start pulse; the job's configuration is held stable until the core reports finish.
// - Returns one tagged response per job: tile count plus an error flag when the watchdog expires.

---
 rtl/job_sched_pkg.sv | 23 ++
 rtl/job_sched_cmd_fifo.sv | 60 ++++++
 rtl/job_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/job_sched_pkg.sv
// rtl/job_sched_pkg.sv - shared types, codes and helpers for the job scheduler
package job_sched_pkg;

    localparam int TILE_W = 16;

    localparam logic [1:0] MODE_MM     = 2'd0;
    localparam logic [1:0] MODE_MM_ACC = 2'd1;
    localparam logic [1:0] MODE_PPU    = 2'd2;
    localparam logic [1:0] MODE_MM_PPU = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [TILE_W-1:0] tile_sat_inc(input logic [TILE_W-1:0] v);
        return (v == {TILE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/job_sched_cmd_fifo.sv
// rtl/job_sched_cmd_fifo.sv - synchronous command FIFO with full/empty/count
module job_sched_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/job_sched.sv
// rtl/job_sched.sv - queues host jobs and launches them one at a time on the accelerator core
module job_sched
    import job_sched_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int TO_CYC = 1048575
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_mode,
    input  logic                       i_cmd_relu,
    input  logic [TAG_W-1:0]           i_cmd_tag,
    output logic                       o_acc_start,
    output logic [1:0]                 o_acc_mode,
    output logic                       o_acc_relu_en,
    input  logic                       i_acc_tile_done,
    input  logic                       i_acc_finish,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [TAG_W-1:0]           o_rsp_tag,
    output logic                       o_rsp_err,
    output logic [TILE_W-1:0]          o_rsp_tiles,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_pending
);

    localparam int FIFO_W = 3 + TAG_W;
    localparam int WD_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TO_CYC > 0) ? WD_W'(TO_CYC - 1) : '0;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] head;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;

    // Ready drops while reset is held so nothing is accepted into a FIFO being cleared
    assign o_cmd_ready = !fifo_full && !i_rst;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign wd_expired  = (TO_CYC != 0) && (wd_cnt == WD_LAST);

    // Entry layout: {mode[1:0], relu, tag}
    job_sched_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_cmd_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (push),
        .wr_data ({i_cmd_mode, i_cmd_relu, i_cmd_tag}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_pending)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: finish takes priority over watchdog expiry in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (i_acc_finish || wd_expired) state_nxt = S_RESP;
            S_RESP:   if (i_rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state control outputs
    always_comb begin
        o_acc_start = 1'b0;
        pop         = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = (state != S_IDLE);
        case (state)
            S_LAUNCH: begin
                o_acc_start = 1'b1;
                pop         = 1'b1;
            end
            S_RESP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Job configuration, tile counter, watchdog and response fields
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_acc_mode    <= '0;
            o_acc_relu_en <= 1'b0;
            o_rsp_tag     <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_tiles   <= '0;
            wd_cnt        <= '0;
        end else begin
            case (state)
                S_LAUNCH: begin
                    o_acc_mode    <= head[FIFO_W-1 -: 2];
                    o_acc_relu_en <= head[TAG_W];
                    o_rsp_tag     <= head[TAG_W-1:0];
                    o_rsp_err     <= 1'b0;
                    o_rsp_tiles   <= '0;
                    wd_cnt        <= '0;
                end
                S_RUN: begin
                    if (i_acc_tile_done) begin
                        o_rsp_tiles <= tile_sat_inc(o_rsp_tiles);
                    end
                    wd_cnt <= wd_cnt + 1'b1;
                    if (!i_acc_finish && wd_expired) begin
                        o_rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
